multi_port_fifo: RTL

Synchronous FIFO that accepts up to MULTI_PUSH entries and releases up to MULTI_POP entries per cycle. It is the next generation of the single-push, multi-pop queue used between fetch/decode and the issue stages. It adds:
- multi-entry push
- full DEPTH capacity, using wrap-bit pointers
- explicit occupancy and free counts
- synchronous flush for pipeline squash
- sticky overflow/underflow flags in place of simulation-only asserts

---
 rtl/multi_port_fifo.sv | 136 +++++++++++++
 1 files changed

// File: rtl/multi_port_fifo.sv
// Multi-push / multi-pop synchronous FIFO with wrap-bit pointers, flush and sticky error flags.
// Optional FIFO_WATERMARK_EN adds a high_water output tracking peak occupancy since reset.
module multi_port_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MULTI_PUSH = 1,
  parameter int unsigned MULTI_POP  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [$clog2(MULTI_PUSH):0]   push_cnt,
  input  logic [DATA_WIDTH-1:0]         data_in [MULTI_PUSH],
  input  logic [$clog2(MULTI_POP):0]    poll_cnt,
  output logic [DATA_WIDTH-1:0]         data_out [MULTI_POP],
  output logic [$clog2(MULTI_POP):0]    ready_cnt,
  output logic [$clog2(DEPTH):0]        free_cnt,
  output logic [$clog2(DEPTH):0]        count,
`ifdef FIFO_WATERMARK_EN
  output logic [$clog2(DEPTH):0]        high_water,
`endif
  output logic                          full,
  output logic                          empty,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          err_clr
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned POW = $clog2(MULTI_POP) + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] w_ptr_q, w_ptr_d;
  logic [PW-1:0] r_ptr_q, r_ptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          push_ok, poll_ok, push_fire;
  logic [AW-1:0] wr_idx [MULTI_PUSH];
  logic [AW-1:0] rd_idx [MULTI_POP];

  // Status is derived purely from registered state.
  always_comb begin
    count    = w_ptr_q - r_ptr_q;
    free_cnt = PW'(DEPTH) - count;
    full     = (count == PW'(DEPTH));
    empty    = (count == '0);
    if (32'(count) >= MULTI_POP) begin
      ready_cnt = POW'(MULTI_POP);
    end else begin
      ready_cnt = POW'(count);
    end
  end

  always_comb begin
    for (int i = 0; i < MULTI_POP; i++) begin
      rd_idx[i]   = r_ptr_q[AW-1:0] + AW'(i);
      data_out[i] = mem[rd_idx[i]];
    end
    for (int k = 0; k < MULTI_PUSH; k++) begin
      wr_idx[k] = w_ptr_q[AW-1:0] + AW'(k);
    end
  end

  // Both checks use pre-cycle counts; a same-cycle poll never makes room for a push.
  assign push_ok   = (32'(push_cnt) <= MULTI_PUSH) && (32'(push_cnt) <= 32'(free_cnt));
  assign poll_ok   = (32'(poll_cnt) <= 32'(ready_cnt));
  assign push_fire = push_ok && !flush && !rst;

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    overflow_d  = overflow_q & ~err_clr;
    underflow_d = underflow_q & ~err_clr;
    if (flush) begin
      r_ptr_d = w_ptr_q;
    end else begin
      if (push_ok) begin
        w_ptr_d = w_ptr_q + PW'(push_cnt);
      end else begin
        overflow_d = 1'b1;
      end
      if (poll_ok) begin
        r_ptr_d = r_ptr_q + PW'(poll_cnt);
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MULTI_PUSH; k++) begin
      if (push_fire && (k < 32'(push_cnt))) begin
        mem[wr_idx[k]] <= data_in[k];
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef FIFO_WATERMARK_EN
  logic [PW-1:0] high_water_q;
  logic [PW-1:0] count_d;

  assign count_d = w_ptr_d - r_ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      high_water_q <= '0;
    end else if (count_d > high_water_q) begin
      high_water_q <= count_d;
    end
  end

  assign high_water = high_water_q;
`endif

endmodule
